morse_rx: RTL

Receive-side counterpart of the Morse encoder's code register and shifter. Times a keyed on/off line in tick units, classifies each mark as dot or dash, and accumulates symbols MSB-first into the same charcode/charlen format the encoder consumes. On a character gap it presents the finished character over a valid/ack handshake. On a word gap it pulses a word-boundary flag. It sits between the key-line synchronizer and the Morse-to-ASCII lookup.

---
 rtl/morse_pkg.sv | 19 +
 rtl/morse_rx_if.sv | 25 ++
 rtl/morse_rx_code_accum.sv | 50 +++++
 rtl/morse_rx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: code format and FSM states shared by the Morse encoder and decoder.
// Exports CHARCODE_W/CHARLEN_W/MAX_SYMS, the SYM_* symbol values and rx_state_e.
package morse_pkg;

  localparam int CHARCODE_W = 8;
  localparam int CHARLEN_W  = 4;
  localparam int MAX_SYMS   = 8;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    WGAP
  } rx_state_e;

endpackage

// File: rtl/morse_rx_if.sv
// morse_rx_if: finished-character valid/ack handshake.
// master drives charcode_data/charlen_data/char_valid, slave drives char_ack.
interface morse_rx_if;
  import morse_pkg::*;

  logic [CHARCODE_W-1:0] charcode_data;
  logic [CHARLEN_W-1:0]  charlen_data;
  logic                  char_valid;
  logic                  char_ack;

  modport master (
    output charcode_data,
    output charlen_data,
    output char_valid,
    input  char_ack
  );

  modport slave (
    input  charcode_data,
    input  charlen_data,
    input  char_valid,
    output char_ack
  );

endinterface

// File: rtl/morse_rx_code_accum.sv
// morse_rx_code_accum: left-justified MSB-first symbol accumulator.
// Ports: clock/reset, i_clear, i_push, i_sym -> o_acc, o_len, o_err.
module morse_rx_code_accum
  import morse_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_push,
  input  logic                  i_sym,
  output logic [CHARCODE_W-1:0] o_acc,
  output logic [CHARLEN_W-1:0]  o_len,
  output logic                  o_err
);

  localparam logic [CHARLEN_W-1:0] LEN_MAX = CHARLEN_W'(MAX_SYMS);
  localparam logic [2:0]           TOP_IDX = 3'(CHARCODE_W - 1);

  logic [CHARCODE_W-1:0] r_acc;
  logic [CHARLEN_W-1:0]  r_len;
  logic                  r_err;
  logic [2:0]            w_idx;

  // First symbol lands in bit 7, later ones fill downward.
  assign w_idx = TOP_IDX - r_len[2:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_len <= '0;
      r_err <= 1'b0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_len <= '0;
      r_err <= 1'b0;
    end else if (i_push) begin
      if (r_len < LEN_MAX) begin
        r_acc[w_idx] <= i_sym;
        r_len        <= r_len + 1'b1;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_acc = r_acc;
  assign o_len = r_len;
  assign o_err = r_err;

endmodule

// File: rtl/morse_rx.sv
// morse_rx: times key_in in ticks, classifies dots/dashes, emits characters.
// Ports: clock/reset, key_in, tick, char_if (master), word_gap, overrun, sym_err.
module morse_rx
  import morse_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int DOT_MAX  = 2,
  parameter int CHAR_GAP = 3,
  parameter int WORD_GAP = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_in,
  input  logic        tick,
  morse_rx_if.master  char_if,
  output logic        word_gap,
  output logic        overrun,
  output logic        sym_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] CHAR_LIM = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WORD_LIM = CNT_W'(WORD_GAP);

  rx_state_e             r_state;
  logic [CNT_W-1:0]      r_mark_cnt;
  logic [CNT_W-1:0]      r_space_cnt;

  logic [CNT_W-1:0]      w_mark_inc;
  logic [CNT_W-1:0]      w_space_inc;
  logic                  w_clear;
  logic                  w_push;
  logic                  w_sym;
  logic [CHARCODE_W-1:0] w_acc;
  logic [CHARLEN_W-1:0]  w_len;
  logic                  w_err;
  logic                  w_ack;

  assign w_mark_inc  = (r_mark_cnt == CNT_MAX) ?
                       r_mark_cnt : r_mark_cnt + 1'b1;
  assign w_space_inc = (r_space_cnt == CNT_MAX) ?
                       r_space_cnt : r_space_cnt + 1'b1;

  // A new character starts on a mark from IDLE or WGAP only;
  // a mark out of SPACE continues the current character.
  assign w_clear = tick & key_in &
                   ((r_state == IDLE) | (r_state == WGAP));
  assign w_push  = tick & ~key_in & (r_state == MARK);
  assign w_sym   = (r_mark_cnt > DOT_LIM) ? SYM_DASH : SYM_DOT;
  assign w_ack   = char_if.char_ack & char_if.char_valid;

  morse_rx_code_accum u_accum (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_sym   (w_sym),
    .o_acc   (w_acc),
    .o_len   (w_len),
    .o_err   (w_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state               <= IDLE;
      r_mark_cnt            <= '0;
      r_space_cnt           <= '0;
      char_if.charcode_data <= '0;
      char_if.charlen_data  <= '0;
      char_if.char_valid    <= 1'b0;
      word_gap              <= 1'b0;
      overrun               <= 1'b0;
      sym_err               <= 1'b0;
    end else begin
      word_gap <= 1'b0;
      overrun  <= 1'b0;
      sym_err  <= 1'b0;
      // A load later in this block overrides the ack clear.
      if (w_ack) char_if.char_valid <= 1'b0;
      if (tick) begin
        unique case (r_state)
          IDLE: begin
            if (key_in) begin
              r_state    <= MARK;
              r_mark_cnt <= 1;
            end
          end
          MARK: begin
            if (key_in) begin
              r_mark_cnt <= w_mark_inc;
            end else begin
              r_space_cnt <= 1;
              r_state     <= SPACE;
            end
          end
          SPACE: begin
            if (key_in) begin
              r_state    <= MARK;
              r_mark_cnt <= 1;
            end else begin
              r_space_cnt <= w_space_inc;
              if (w_space_inc == CHAR_LIM) begin
                r_state <= WGAP;
                if (w_err) begin
                  sym_err <= 1'b1;
                end else if (!char_if.char_valid || w_ack) begin
                  char_if.charcode_data <= w_acc;
                  char_if.charlen_data  <= w_len;
                  char_if.char_valid    <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end
          end
          WGAP: begin
            if (key_in) begin
              r_state    <= MARK;
              r_mark_cnt <= 1;
            end else begin
              r_space_cnt <= w_space_inc;
              if (w_space_inc == WORD_LIM) begin
                word_gap <= 1'b1;
                r_state  <= IDLE;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
